// File: rtl/trig_nco_if.sv
// rtl/trig_nco_if.sv - sample request / sine-cosine result bundle for trig_nco
interface trig_nco_if #(
    parameter int VALUE_WIDTH = 32,
    parameter int ANGLE_WIDTH = 10,
    parameter int PHASE_WIDTH = 24
);
    logic                          en;
    logic                          load;
    logic [PHASE_WIDTH-1:0]        freq_in;
    logic [PHASE_WIDTH-1:0]        phase_off;
    logic signed [VALUE_WIDTH-1:0] sin_out;
    logic signed [VALUE_WIDTH-1:0] cos_out;
    logic [ANGLE_WIDTH-1:0]        angle_out;
    logic                          valid_out;

    modport master (
        output en, load, freq_in, phase_off,
        input  sin_out, cos_out, angle_out, valid_out
    );

    modport slave (
        input  en, load, freq_in, phase_off,
        output sin_out, cos_out, angle_out, valid_out
    );
endinterface

// File: rtl/trig_nco.sv
// rtl/trig_nco.sv - three-stage phase accumulator NCO with quarter-wave folded sine/cosine
module trig_nco #(
    parameter int VALUE_WIDTH = 32,
    parameter int ANGLE_WIDTH = 10,
    parameter int PHASE_WIDTH = 24
) (
    input logic       clk,
    input logic       rst_n,
    trig_nco_if.slave bus
);
    localparam int QW = 1 << (ANGLE_WIDTH - 2);

    // Quarter-wave table, entries 0..QW inclusive, computed at elaboration.
    function automatic logic [VALUE_WIDTH-1:0] rom_val(input int k);
        real amp;
        real x;
        amp = (2.0 ** (VALUE_WIDTH - 1)) - 1.0;
        x   = amp * $sin(2.0 * 3.14159265358979323846 * k / (2.0 ** ANGLE_WIDTH));
        return VALUE_WIDTH'(longint'($floor(x + 0.5)));
    endfunction

    logic [VALUE_WIDTH-1:0] rom [0:QW];

    for (genvar k = 0; k <= QW; k++) begin : g_rom
        assign rom[k] = rom_val(k);
    end

    // Stage 1: accumulator and angle capture
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] base;
    logic [ANGLE_WIDTH-1:0] angle_next;
    logic [ANGLE_WIDTH-1:0] angle1;
    logic                   v1;

    assign base       = bus.load ? '0 : acc;
    assign angle_next = ANGLE_WIDTH'((base + bus.phase_off) >> (PHASE_WIDTH - ANGLE_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            angle1 <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= bus.en;
            if (bus.en) begin
                angle1 <= angle_next;
                acc    <= base + bus.freq_in;
            end else if (bus.load) begin
                acc <= '0;
            end
        end
    end

    // Stage 2: quadrant fold, two table reads and sign flags
    logic [1:0]             quad;
    logic [ANGLE_WIDTH-2:0] idx_lo;
    logic [ANGLE_WIDTH-2:0] idx_hi;
    logic [VALUE_WIDTH-1:0] mag_s;
    logic [VALUE_WIDTH-1:0] mag_c;
    logic                   neg_s;
    logic                   neg_c;
    logic [ANGLE_WIDTH-1:0] angle2;
    logic                   v2;

    assign quad   = angle1[ANGLE_WIDTH-1 -: 2];
    assign idx_lo = {1'b0, angle1[ANGLE_WIDTH-3:0]};
    assign idx_hi = (ANGLE_WIDTH-1)'(QW) - idx_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_s  <= '0;
            mag_c  <= '0;
            neg_s  <= 1'b0;
            neg_c  <= 1'b0;
            angle2 <= '0;
            v2     <= 1'b0;
        end else begin
            // Odd quadrants read the mirrored index for sine and the direct one for cosine.
            mag_s  <= quad[0] ? rom[idx_hi] : rom[idx_lo];
            mag_c  <= quad[0] ? rom[idx_lo] : rom[idx_hi];
            neg_s  <= quad[1];
            neg_c  <= quad[1] ^ quad[0];
            angle2 <= angle1;
            v2     <= v1;
        end
    end

    // Stage 3: sign application; sample registers hold through bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sin_out   <= '0;
            bus.cos_out   <= '0;
            bus.angle_out <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= v2;
            if (v2) begin
                bus.sin_out   <= neg_s ? -mag_s : mag_s;
                bus.cos_out   <= neg_c ? -mag_c : mag_c;
                bus.angle_out <= angle2;
            end
        end
    end
endmodule

// File: tb/tb_trig_nco.sv
// tb/tb_trig_nco.sv - randomized and directed self-checking bench for trig_nco
module tb_trig_nco;
    localparam int VW = 32;
    localparam int AW = 10;
    localparam int PW = 24;
    localparam longint PMOD = 64'd1 << PW;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    trig_nco_if #(.VALUE_WIDTH(VW), .ANGLE_WIDTH(AW), .PHASE_WIDTH(PW)) bus ();

    trig_nco #(.VALUE_WIDTH(VW), .ANGLE_WIDTH(AW), .PHASE_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic longint round_away(input real v);
        if (v >= 0.0) return longint'($floor(v + 0.5));
        return -longint'($floor(0.5 - v));
    endfunction

    function automatic longint ref_sin(input int k);
        return round_away(2147483647.0 * $sin(2.0 * PI * k / 1024.0));
    endfunction

    function automatic longint ref_cos(input int k);
        return round_away(2147483647.0 * $cos(2.0 * PI * k / 1024.0));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase arithmetic on integers, 2-edge sample delay as a queue.
    typedef struct { bit v; int a; } samp_t;
    samp_t  pipe[$];
    longint macc;
    bit     exp_valid;
    int     exp_ang;
    longint exp_sin, exp_cos;

    always @(posedge clk or negedge rst_n) begin
        samp_t s, t;
        longint base;
        if (!rst_n) begin
            macc = 0;
            pipe.delete();
            exp_valid = 0;
            exp_ang = 0;
            exp_sin = 0;
            exp_cos = 0;
        end else begin
            if (bus.en) begin
                base = bus.load ? 0 : macc;
                s.v  = 1;
                s.a  = int'(((base + longint'(bus.phase_off)) % PMOD) / (64'd1 << (PW - AW)));
                macc = (base + longint'(bus.freq_in)) % PMOD;
            end else begin
                s.v = 0;
                s.a = 0;
                if (bus.load) macc = 0;
            end
            pipe.push_back(s);
            if (pipe.size() == 3) begin
                t = pipe.pop_front();
                exp_valid = t.v;
                if (t.v) begin
                    exp_ang = t.a;
                    exp_sin = ref_sin(t.a);
                    exp_cos = ref_cos(t.a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_out", longint'(bus.valid_out), longint'(exp_valid));
            chk("angle_out", longint'(bus.angle_out), longint'(exp_ang));
            chk("sin_out", longint'(bus.sin_out), exp_sin);
            chk("cos_out", longint'(bus.cos_out), exp_cos);
            if (bus.valid_out && bus.angle_out == 10'd256) begin
                chk("sin_256", longint'(bus.sin_out), 2147483647);
                chk("cos_256", longint'(bus.cos_out), 0);
            end
            if (bus.valid_out && bus.angle_out == 10'd512) begin
                chk("sin_512", longint'(bus.sin_out), 0);
                chk("cos_512", longint'(bus.cos_out), -2147483647);
            end
            if (bus.valid_out && bus.angle_out == 10'd768) begin
                chk("sin_768", longint'(bus.sin_out), -2147483647);
                chk("cos_768", longint'(bus.cos_out), 0);
            end
            if (bus.valid_out && bus.angle_out == 10'd1023)
                chk("sin_1023_negative", longint'(bus.sin_out < 0), 1);
        end
    end

    task automatic cyc(input bit e, input bit l);
        bus.en   = e;
        bus.load = l;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.en = 0;
        bus.load = 0;
        bus.freq_in = '0;
        bus.phase_off = '0;

        chk("model_sin_256", ref_sin(256), 2147483647);
        chk("model_cos_512", ref_cos(512), -2147483647);
        chk("model_sin_768", ref_sin(768), -2147483647);
        chk("model_cos_256", ref_cos(256), 0);
        chk("model_sin_0", ref_sin(0), 0);

        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", longint'(bus.valid_out), 0);
        chk("reset_sin", longint'(bus.sin_out), 0);
        rst_n = 1;

        // Full sweep from a fresh reset, then drain
        bus.freq_in = 24'd1 << 14;
        repeat (1027) cyc(1, 0);
        repeat (3) cyc(0, 0);

        // Enable gaps restarted from phase 0
        cyc(1, 1);
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 0);
        repeat (3) cyc(0, 0);

        // Load mid-run
        bus.freq_in   = 24'(5 << 14);
        bus.phase_off = 24'(100 << 14);
        repeat (6) cyc(1, 0);
        cyc(1, 1);
        cyc(1, 0);
        cyc(1, 0);
        chk("load_angle", longint'(bus.angle_out), 100);
        chk("load_valid", longint'(bus.valid_out), 1);
        cyc(1, 0);
        chk("load_next_angle", longint'(bus.angle_out), 105);
        repeat (3) cyc(0, 0);

        // Quarter-turn offset sweep
        bus.freq_in   = 24'd1 << 14;
        bus.phase_off = 24'd1 << 22;
        cyc(1, 1);
        repeat (1025) cyc(1, 0);
        repeat (3) cyc(0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.freq_in = 24'($urandom);
            if ($urandom_range(0, 7) == 0) bus.phase_off = 24'($urandom);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        // Reset mid-run, released with en low
        repeat (5) cyc(1, 0);
        rst_n = 0;
        #1;
        chk("midreset_sin", longint'(bus.sin_out), 0);
        chk("midreset_cos", longint'(bus.cos_out), 0);
        chk("midreset_angle", longint'(bus.angle_out), 0);
        chk("midreset_valid", longint'(bus.valid_out), 0);
        bus.en = 0;
        @(posedge clk);
        #2;
        rst_n = 1;
        repeat (5) cyc(0, 0);
        chk("post_reset_valid", longint'(bus.valid_out), 0);

        // Offset after release: first sample angle = top bits of phase_off
        bus.phase_off = 24'(37 << 14);
        bus.freq_in   = 24'(3 << 14);
        repeat (3) cyc(1, 0);
        chk("release_angle", longint'(bus.angle_out), 37);
        repeat (4) cyc(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
